// File: rtl/obi_subordinate_if.sv
// OBI v1 A/R channel bundle shared by the requesting master and the subordinate.
interface obi_subordinate_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic                  req;
   logic                  gnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [BE_W-1:0]       be;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  err;

   modport master (
      output req, addr, we, be, wdata, rready,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata, rready,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/obi_subordinate.sv
// OBI v1 responder backed by a small register-array scratchpad, with optional
// grant stall and an in-order response FIFO bounding outstanding transactions.
module obi_subordinate #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_WORDS  = 16,
   parameter logic [63:0] BASE_ADDR  = 64'h0,
   parameter int unsigned RSP_DEPTH  = 2,
   parameter int unsigned GNT_STALL  = 0
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   obi_subordinate_if.slave                 obi,
   output logic [$clog2(RSP_DEPTH+1)-1:0]   outstanding_o
);
   localparam int unsigned BE_W    = DATA_WIDTH / 8;
   localparam int unsigned OFF_LSB = $clog2(BE_W);
   localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
   localparam int unsigned PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned OCC_W   = $clog2(RSP_DEPTH + 1);
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned SPAN    = NUM_WORDS * BE_W;

   typedef enum logic {A_IDLE, A_WAIT} a_state_e;

   typedef struct packed {
      logic                  err;
      logic [DATA_WIDTH-1:0] data;
   } rsp_t;

   a_state_e              state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
   logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
   rsp_t                  fifo_q [RSP_DEPTH];
   rsp_t                  fifo_d [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] off;
   logic                  hit;
   logic [IDX_W-1:0]      idx;
   logic                  eligible;
   logic                  gnt_c;
   logic                  pop;
   logic                  rvalid_c;
   rsp_t                  push_rsp;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(RSP_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // Address decode: in range of the window and word aligned.
   assign base = ADDR_WIDTH'(BASE_ADDR);
   assign off  = obi.addr - base;
   assign hit  = (obi.addr >= base) && (off < ADDR_WIDTH'(SPAN)) &&
                 (off[OFF_LSB-1:0] == '0);
   assign idx  = off[OFF_LSB +: IDX_W];

   always_comb begin
      eligible = 1'b0;
      if (GNT_STALL == 0) eligible = (state_q == A_IDLE);
      else                eligible = (state_q == A_WAIT) && (cnt_q == CNT_W'(GNT_STALL));
   end

   // A full FIFO blocks the grant even when the head pops this cycle.
   assign gnt_c    = obi.req && eligible && (occ_q < OCC_W'(RSP_DEPTH)) && !reset_i;
   assign rvalid_c = (occ_q != '0);
   assign pop      = rvalid_c && obi.rready;

   assign obi.gnt       = gnt_c;
   assign obi.rvalid    = rvalid_c;
   assign obi.rdata     = rvalid_c ? fifo_q[rd_ptr_q].data : '0;
   assign obi.err       = rvalid_c ? fifo_q[rd_ptr_q].err  : 1'b0;
   assign outstanding_o = occ_q;

   // Grant-stall FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         A_IDLE: begin
            cnt_d = '0;
            if (obi.req && (GNT_STALL != 0)) begin
               state_d = A_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         A_WAIT: begin
            if (gnt_c || !obi.req) begin
               state_d = A_IDLE;
               cnt_d   = '0;
            end else if (cnt_q != CNT_W'(GNT_STALL)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = A_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Storage update and response formation on accept.
   always_comb begin
      mem_d = mem_q;
      if (gnt_c && hit && obi.we) begin
         for (int k = 0; k < BE_W; k++) begin
            if (obi.be[k]) mem_d[idx][8*k +: 8] = obi.wdata[8*k +: 8];
         end
      end
      push_rsp.err  = !hit;
      push_rsp.data = (hit && !obi.we) ? mem_q[idx] : '0;
   end

   // Response FIFO; occupancy counter resolves full vs empty.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (gnt_c) begin
         fifo_d[wr_ptr_q] = push_rsp;
         wr_ptr_d         = next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      if (gnt_c && !pop)      occ_d = occ_q + OCC_W'(1);
      else if (!gnt_c && pop) occ_d = occ_q - OCC_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= A_IDLE;
         cnt_q    <= '0;
         mem_q    <= '{default: '0};
         fifo_q   <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
         fifo_q   <= fifo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end
endmodule

// File: tb/tb_obi_subordinate.sv
// Directed bench for obi_subordinate: one zero-stall instance and one with GNT_STALL=3.
module tb_obi_subordinate;
   logic       clk;
   logic       reset;
   logic [1:0] out0;
   logic [1:0] out1;
   int         vec;
   int         errs;

   obi_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   obi_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   obi_subordinate #(.GNT_STALL(0)) u_dut (
      .clk_i(clk), .reset_i(reset), .obi(bus0.slave), .outstanding_o(out0)
   );

   obi_subordinate #(.GNT_STALL(3)) u_stall (
      .clk_i(clk), .reset_i(reset), .obi(bus1.slave), .outstanding_o(out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end

   task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
      bus0.req = req; bus0.we = we; bus0.addr = addr; bus0.be = be; bus0.wdata = wdata;
   endtask

   // Single transfer on bus0 with rready=1; returns what was observed.
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic g, output logic rv,
                       output logic [31:0] rd, output logic e);
      @(negedge clk); drive0(1'b1, we, addr, be, wdata); #1;
      g = bus0.gnt;
      @(negedge clk); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
      rv = bus0.rvalid; rd = bus0.rdata; e = bus0.err;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      bus0.rready = 1'b1;
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 32'h0; bus1.be = 4'h0;
      bus1.wdata = 32'h0; bus1.rready = 1'b1;
      @(negedge clk); @(negedge clk);
      drive0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0); bus1.req = 1'b1; #1;
      vec++; if (bus0.gnt !== 1'b0) begin errs++; $display("FAIL rst_gnt0: got %b want 0", bus0.gnt); end
      vec++; if (bus1.gnt !== 1'b0) begin errs++; $display("FAIL rst_gnt1: got %b want 0", bus1.gnt); end
      @(negedge clk);
      drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); bus1.req = 1'b0; reset = 1'b0; #1;
      vec++; if (bus0.rvalid !== 1'b0) begin errs++; $display("FAIL rst_rvalid: got %b want 0", bus0.rvalid); end
      vec++; if (bus0.rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", bus0.rdata); end
      vec++; if (bus0.err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", bus0.err); end
      vec++; if (out0 !== 2'd0) begin errs++; $display("FAIL rst_out0: got %0d want 0", out0); end
      vec++; if (out1 !== 2'd0) begin errs++; $display("FAIL rst_out1: got %0d want 0", out1); end
   endtask

   task automatic test_write_read();
      @(negedge clk); drive0(1'b1, 1'b1, 32'h4, 4'hF, 32'hDEADBEEF); #1;
      vec++; if (bus0.gnt !== 1'b1) begin errs++; $display("FAIL wr_gnt: got %b want 1", bus0.gnt); end
      @(negedge clk); drive0(1'b1, 1'b0, 32'h4, 4'hF, 32'h0); #1;
      vec++; if (bus0.rvalid !== 1'b1) begin errs++; $display("FAIL wr_rvalid: got %b want 1", bus0.rvalid); end
      vec++; if (bus0.rdata !== 32'h0) begin errs++; $display("FAIL wr_rdata: got %h want 0", bus0.rdata); end
      vec++; if (bus0.err !== 1'b0) begin errs++; $display("FAIL wr_err: got %b want 0", bus0.err); end
      vec++; if (bus0.gnt !== 1'b1) begin errs++; $display("FAIL rd_gnt: got %b want 1", bus0.gnt); end
      @(negedge clk); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
      vec++; if (bus0.rvalid !== 1'b1) begin errs++; $display("FAIL rd_rvalid: got %b want 1", bus0.rvalid); end
      vec++; if (bus0.rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_data: got %h want deadbeef", bus0.rdata); end
      @(negedge clk); #1;
      vec++; if (bus0.rvalid !== 1'b0) begin errs++; $display("FAIL rd_drain: got %b want 0", bus0.rvalid); end
      vec++; if (out0 !== 2'd0) begin errs++; $display("FAIL rd_out: got %0d want 0", out0); end
   endtask

   task automatic test_byte_enable();
      logic g, rv, e; logic [31:0] rd;
      xfer(1'b1, 32'h8, 4'hF, 32'h11223344, g, rv, rd, e);
      vec++; if (g !== 1'b1) begin errs++; $display("FAIL be_wr1_gnt: got %b want 1", g); end
      xfer(1'b1, 32'h8, 4'h5, 32'hAABBCCDD, g, rv, rd, e);
      vec++; if (rd !== 32'h0) begin errs++; $display("FAIL be_wr2_rdata: got %h want 0", rd); end
      xfer(1'b0, 32'h8, 4'h1, 32'h0, g, rv, rd, e);
      vec++; if (rv !== 1'b1) begin errs++; $display("FAIL be_rvalid: got %b want 1", rv); end
      vec++; if (rd !== 32'h11BB33DD) begin errs++; $display("FAIL be_merge: got %h want 11bb33dd", rd); end
   endtask

   task automatic test_errors();
      logic g, rv, e; logic [31:0] rd;
      xfer(1'b0, 32'h40, 4'hF, 32'h0, g, rv, rd, e);
      vec++; if (e !== 1'b1) begin errs++; $display("FAIL oor_err: got %b want 1", e); end
      vec++; if (rd !== 32'h0) begin errs++; $display("FAIL oor_rdata: got %h want 0", rd); end
      xfer(1'b0, 32'h2, 4'hF, 32'h0, g, rv, rd, e);
      vec++; if (e !== 1'b1) begin errs++; $display("FAIL mis_err: got %b want 1", e); end
      vec++; if (rd !== 32'h0) begin errs++; $display("FAIL mis_rdata: got %h want 0", rd); end
      xfer(1'b0, 32'h0, 4'hF, 32'h0, g, rv, rd, e);
      vec++; if ({e, rd} !== 33'h0) begin errs++; $display("FAIL word0: got err=%b data=%h want 0/0", e, rd); end
      xfer(1'b1, 32'h44, 4'hF, 32'h55555555, g, rv, rd, e);
      vec++; if (e !== 1'b1) begin errs++; $display("FAIL wr_miss_err: got %b want 1", e); end
      xfer(1'b1, 32'h3C, 4'hF, 32'hCAFEF00D, g, rv, rd, e);
      vec++; if (e !== 1'b0) begin errs++; $display("FAIL last_wr_err: got %b want 0", e); end
      xfer(1'b0, 32'h3C, 4'hF, 32'h0, g, rv, rd, e);
      vec++; if (rd !== 32'hCAFEF00D) begin errs++; $display("FAIL last_word: got %h want cafef00d", rd); end
      xfer(1'b0, 32'h4, 4'hF, 32'h0, g, rv, rd, e);
      vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL miss_nocorrupt: got %h want deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); bus0.rready = 1'b0; drive0(1'b1, 1'b0, 32'h4, 4'hF, 32'h0); #1;
      vec++; if (bus0.gnt !== 1'b1) begin errs++; $display("FAIL b2b_gnt1: got %b want 1", bus0.gnt); end
      @(negedge clk); drive0(1'b1, 1'b0, 32'h8, 4'hF, 32'h0); #1;
      vec++; if (bus0.gnt !== 1'b1) begin errs++; $display("FAIL b2b_gnt2: got %b want 1", bus0.gnt); end
      vec++; if (out0 !== 2'd1) begin errs++; $display("FAIL b2b_out1: got %0d want 1", out0); end
      @(negedge clk); drive0(1'b1, 1'b0, 32'h3C, 4'hF, 32'h0); #1;
      vec++; if (bus0.gnt !== 1'b0) begin errs++; $display("FAIL b2b_full_gnt: got %b want 0", bus0.gnt); end
      vec++; if (out0 !== 2'd2) begin errs++; $display("FAIL b2b_out2: got %0d want 2", out0); end
      vec++; if (bus0.rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL b2b_head: got %h want deadbeef", bus0.rdata); end
      @(negedge clk); #1;
      vec++; if (bus0.gnt !== 1'b0) begin errs++; $display("FAIL b2b_hold_gnt: got %b want 0", bus0.gnt); end
      vec++; if ({bus0.rvalid, bus0.rdata} !== {1'b1, 32'hDEADBEEF}) begin errs++; $display("FAIL b2b_head_stable: got %b/%h want 1/deadbeef", bus0.rvalid, bus0.rdata); end
      @(negedge clk); bus0.rready = 1'b1; #1;
      vec++; if (bus0.gnt !== 1'b0) begin errs++; $display("FAIL b2b_no_pop_through: got %b want 0", bus0.gnt); end
      @(negedge clk); #1;
      vec++; if (bus0.gnt !== 1'b1) begin errs++; $display("FAIL b2b_gnt3: got %b want 1", bus0.gnt); end
      vec++; if (bus0.rdata !== 32'h11BB33DD) begin errs++; $display("FAIL b2b_rsp2: got %h want 11bb33dd", bus0.rdata); end
      @(negedge clk); drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
      vec++; if (bus0.rdata !== 32'hCAFEF00D) begin errs++; $display("FAIL b2b_rsp3: got %h want cafef00d", bus0.rdata); end
      vec++; if (out0 !== 2'd1) begin errs++; $display("FAIL b2b_out_last: got %0d want 1", out0); end
      @(negedge clk); #1;
      vec++; if ({bus0.rvalid, out0} !== 3'b0_00) begin errs++; $display("FAIL b2b_empty: got %b/%0d want 0/0", bus0.rvalid, out0); end
   endtask

   task automatic test_stall();
      int lat;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h4; bus1.be = 4'hF;
         lat = -1;
         for (int i = 0; i < 10; i++) begin
            #1;
            if (bus1.gnt === 1'b1) begin lat = i; break; end
            @(negedge clk);
         end
         vec++; if (lat != 3) begin errs++; $display("FAIL stall_latency%0d: got %0d want 3", r, lat); end
         @(negedge clk); bus1.req = 1'b0; #1;
         vec++; if (bus1.rvalid !== 1'b1) begin errs++; $display("FAIL stall_rvalid%0d: got %b want 1", r, bus1.rvalid); end
         vec++; if (bus1.err !== 1'b0) begin errs++; $display("FAIL stall_err%0d: got %b want 0", r, bus1.err); end
      end
   endtask

   task automatic test_reset_mid();
      logic g, rv, e; logic [31:0] rd;
      @(negedge clk); bus0.rready = 1'b0; drive0(1'b1, 1'b0, 32'h4, 4'hF, 32'h0); #1;
      vec++; if (bus0.gnt !== 1'b1) begin errs++; $display("FAIL rm_gnt1: got %b want 1", bus0.gnt); end
      @(negedge clk); drive0(1'b1, 1'b0, 32'h8, 4'hF, 32'h0); #1;
      vec++; if (bus0.gnt !== 1'b1) begin errs++; $display("FAIL rm_gnt2: got %b want 1", bus0.gnt); end
      @(negedge clk); drive0(1'b1, 1'b0, 32'h3C, 4'hF, 32'h0); reset = 1'b1; #1;
      vec++; if (bus0.gnt !== 1'b0) begin errs++; $display("FAIL rm_gnt_rst: got %b want 0", bus0.gnt); end
      @(negedge clk); reset = 1'b0; drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); bus0.rready = 1'b1; #1;
      vec++; if (bus0.rvalid !== 1'b0) begin errs++; $display("FAIL rm_rvalid: got %b want 0", bus0.rvalid); end
      vec++; if (out0 !== 2'd0) begin errs++; $display("FAIL rm_out: got %0d want 0", out0); end
      xfer(1'b0, 32'h4, 4'hF, 32'h0, g, rv, rd, e);
      vec++; if ({rv, rd} !== {1'b1, 32'h0}) begin errs++; $display("FAIL rm_mem_cleared: got %b/%h want 1/0", rv, rd); end
   endtask

   initial begin
      vec  = 0;
      errs = 0;
      test_reset();
      test_write_read();
      test_byte_enable();
      test_errors();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/obi_subordinate.md
Name: obi_subordinate

Overview:
- OBI v1 responder: the subordinate end of the bus that obi_master drives.
- Backs a register-array memory of NUM_WORDS words and accepts A-channel requests with optional programmable grant stall.
- Returns R-channel responses through an in-order response FIFO, so up to RSP_DEPTH transactions can be outstanding.
- Serves as the bench target for obi_master and as a small on-bus scratchpad.

Parameters:
- ADDR_WIDTH, 32: address width (32 or 64).
- DATA_WIDTH, 32: data width (32 or 64); BE_W = DATA_WIDTH/8.
- NUM_WORDS, 16: storage depth in words (power of two, >= 2).
- BASE_ADDR, 0: byte address of word 0 (aligned to NUM_WORDS*BE_W).
- RSP_DEPTH, 2: response FIFO depth, equal to the maximum outstanding transactions (>= 1).
- GNT_STALL, 0: wait cycles inserted between req seen and gnt asserted (0 to 15).

Ports:
- clk_i, input, 1: clock; all logic is on the rising edge.
- reset_i, input, 1: synchronous, active-high reset.
- obi_req_i, input, 1: A-channel request.
- obi_gnt_o, output, 1: A-channel grant.
- obi_addr_i, input, ADDR_WIDTH: byte address.
- obi_we_i, input, 1: 1 = write, 0 = read.
- obi_be_i, input, BE_W: byte enables.
- obi_wdata_i, input, DATA_WIDTH: write data.
- obi_rvalid_o, output, 1: R-channel valid.
- obi_rready_i, input, 1: R-channel ready.
- obi_rdata_o, output, DATA_WIDTH: read data (0 for writes and errors).
- obi_err_o, output, 1: response error.
- outstanding_o, output, $clog2(RSP_DEPTH+1): current FIFO occupancy.

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - Clears the FIFO, storage array (all zero), stall counter and A-FSM (to A_IDLE).
  - Any queued responses are discarded.
  - During a cycle with reset_i=1, obi_gnt_o=0.
  - After reset: obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0, outstanding_o=0.
- Address decode:
  - off = addr - BASE_ADDR.
  - Hit when addr >= BASE_ADDR, off < NUM_WORDS*BE_W, and off[log2(BE_W)-1:0]==0.
  - Word index = off >> log2(BE_W).
  - A miss or misalignment is an error.
- A-FSM states:
  - A_IDLE: cnt=0. If req_i && GNT_STALL==0, grant in this state. If req_i && GNT_STALL>0, go to A_WAIT with cnt=1.
  - A_WAIT: cnt increments each cycle, saturating at GNT_STALL. Grant is eligible when cnt==GNT_STALL. Return to A_IDLE on handshake.
  - req dropping in A_WAIT (protocol violation) also returns to A_IDLE.
- Grant rule:
  - obi_gnt_o = obi_req_i && eligible && (outstanding_o < RSP_DEPTH) && !reset_i.
  - Combinational from req; there is no pop-through-when-full, so a full FIFO blocks gnt even if rready=1 that cycle.
  - Minimum request-to-grant latency is GNT_STALL cycles.
- Accept (req && gnt at a clock edge):
  - Write hit: word[i][8k+7:8k] <= wdata byte k for each set be bit. Push {rdata=0, err=0}. be=0 is a legal no-op write.
  - Read hit: push {rdata=word[i] (pre-edge value, full word regardless of be), err=0}.
  - Miss: no storage change; push {rdata=0, err=1}.
- R channel:
  - obi_rvalid_o = FIFO not empty; obi_rdata_o/obi_err_o = FIFO head, and 0 when empty.
  - Earliest rvalid is the cycle after accept (latency 1).
  - Pop on rvalid && rready. Simultaneous push and pop leaves occupancy unchanged.
  - Head outputs stay stable while rvalid && !rready.
  - Responses return strictly in accept order.
- Read-after-write:
  - A read accepted the cycle after a write to the same word returns the new data.
  - A read and a write cannot be accepted in the same cycle.
- FIFO pointers wrap modulo RSP_DEPTH; the full/empty distinction uses the occupancy counter.

Test Plan:
- Reset, then write addr 0x4, be 0xF, wdata 0xDEADBEEF; then read 0x4 with rready=1. Required: gnt in the same cycle as req; write response rvalid=1, rdata=0, err=0 one cycle later; read response rdata=0xDEADBEEF.
- Write 0x8 with 0x11223344, then write 0x8 with be 0x5, wdata 0xAABBCCDD; then read. Required: read returns 0x11BB33DD.
- Read 0x40 (out of range, NUM_WORDS=16) and read 0x2 (misaligned). Required: each response has err=1, rdata=0; a subsequent read of word 0 returns 0.
- rready=0 while issuing 3 back-to-back reads (RSP_DEPTH=2). Required: 2 grants, outstanding_o=2, third req ungranted with rvalid head held stable; raise rready, then the third is granted after the first pop, and all 3 responses return in order.
- GNT_STALL=3, single read. Required: gnt rises exactly 3 cycles after req first asserts; rvalid follows 1 cycle after gnt.
- Assert reset_i while 2 responses are queued and req is high. Required: gnt=0 during reset; next cycle rvalid=0, outstanding_o=0; read of a previously written word returns 0.
